// File: rtl/clk_rst_seq_pkg.sv
// Shared definitions for the CLKCMS reset/startup sequencer: state encodings,
// lock-loss counter sizing and dwell counter width helper.
package clk_rst_seq_pkg;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_CORE   = 3'd1,
    S_FIFO   = 3'd2,
    S_SETTLE = 3'd3,
    S_RUN    = 3'd4,
    S_LOST   = 3'd5,
    S_SOFT   = 3'd6
  } state_e;

  localparam int                LOSS_W   = 8;
  localparam logic [LOSS_W-1:0] LOSS_MAX = 8'd255;

  // Width needed to hold the largest dwell length itself, not just length-1.
  function automatic int cnt_width(input int stable_cyc, input int gap_cyc, input int fifo_cyc);
    int m;
    m = stable_cyc;
    if (gap_cyc > m) m = gap_cyc;
    if (fifo_cyc > m) m = fifo_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_rst_seq_timer.sv
// Dwell counter for the sequencer: synchronous clear wins over enable.
// tc_o compares the current count against the terminal value chosen per state.
module clk_rst_seq_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/clk_rst_seq.sv
// Reset/startup sequencer on CLKCMS: staged release of core reset, FIFO reset and L1A
// enable after a stable lock, with lock-loss re-sequencing and a saturating loss counter.
module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int STABLE_CYC   = 1024,
  parameter int GAP_CYC      = 8,
  parameter int FIFO_RST_CYC = 16,
  parameter int CNT_W        = cnt_width(STABLE_CYC, GAP_CYC, FIFO_RST_CYC)
) (
  input  logic              CLKCMS,
  input  logic              RST_B,
  input  logic              READY,
  input  logic              SOFT_RST,
  input  logic              CLR_LOSS,
  output logic              CORE_RST,
  output logic              FIFO_RST,
  output logic              L1A_EN,
  output logic              RUNNING,
  output logic [2:0]        STATE,
  output logic [LOSS_W-1:0] LOSS_CNT
);

  state_e             state_q, state_d;
  logic               core_rst_q, core_rst_d;
  logic               fifo_rst_q, fifo_rst_d;
  logic               l1a_en_q, l1a_en_d;
  logic               running_q, running_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;

  logic               tc;
  logic               lock_loss;
  logic               soft_go;
  logic               timer_clr;
  logic               timer_en;
  logic [CNT_W-1:0]   term;

  always_ff @(posedge CLKCMS or negedge RST_B) begin
    if (!RST_B) begin
      state_q    <= S_WAIT;
      core_rst_q <= 1'b1;
      fifo_rst_q <= 1'b1;
      l1a_en_q   <= 1'b0;
      running_q  <= 1'b0;
      loss_q     <= '0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= core_rst_d;
      fifo_rst_q <= fifo_rst_d;
      l1a_en_q   <= l1a_en_d;
      running_q  <= running_d;
      loss_q     <= loss_d;
    end
  end

  always_comb begin
    lock_loss = !READY && (state_q inside {S_CORE, S_FIFO, S_SETTLE, S_RUN, S_SOFT});
    soft_go   = SOFT_RST && (state_q inside {S_CORE, S_FIFO, S_SETTLE, S_RUN});

    state_d = state_q;
    case (state_q)
      S_WAIT:   if (READY && tc) state_d = S_CORE;
      S_CORE:   if (tc)          state_d = S_FIFO;
      S_FIFO:   if (tc)          state_d = S_SETTLE;
      S_SETTLE: if (tc)          state_d = S_RUN;
      S_RUN:                     state_d = S_RUN;
      S_LOST:                    state_d = S_WAIT;
      S_SOFT:   if (tc)          state_d = S_CORE;
      default:                   state_d = S_WAIT;
    endcase
    if (soft_go)   state_d = S_SOFT;
    if (lock_loss) state_d = S_LOST;

    loss_d = loss_q;
    if (CLR_LOSS)                             loss_d = '0;
    else if (lock_loss && loss_q != LOSS_MAX) loss_d = loss_q + LOSS_W'(1);
  end

  // Outputs decode the next state so they update on the same edge as STATE.
  always_comb begin
    core_rst_d = 1'b1;
    fifo_rst_d = 1'b1;
    l1a_en_d   = 1'b0;
    running_d  = 1'b0;
    case (state_d)
      S_CORE, S_FIFO: core_rst_d = 1'b0;
      S_SETTLE: begin
        core_rst_d = 1'b0;
        fifo_rst_d = 1'b0;
      end
      S_RUN: begin
        core_rst_d = 1'b0;
        fifo_rst_d = 1'b0;
        l1a_en_d   = 1'b1;
        running_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // In S_WAIT the count measures consecutive READY-high cycles only.
  always_comb begin
    timer_clr = (state_d != state_q) || (state_q == S_WAIT && !READY);
    timer_en  = (state_q != S_WAIT) || READY;
    case (state_q)
      S_WAIT:                 term = CNT_W'(STABLE_CYC - 1);
      S_CORE, S_SETTLE, S_SOFT: term = CNT_W'(GAP_CYC - 1);
      S_FIFO:                 term = CNT_W'(FIFO_RST_CYC - 1);
      default:                term = '0;
    endcase
  end

  clk_rst_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i   (CLKCMS),
    .rst_n_i (RST_B),
    .clr_i   (timer_clr),
    .en_i    (timer_en),
    .term_i  (term),
    .tc_o    (tc)
  );

  assign CORE_RST = core_rst_q;
  assign FIFO_RST = fifo_rst_q;
  assign L1A_EN   = l1a_en_q;
  assign RUNNING  = running_q;
  assign STATE    = state_q;
  assign LOSS_CNT = loss_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: default-parameter instance checked against fixed timing,
// short-parameter instance checked against a cycle-level behavioural model.
module tb_clk_rst_seq;

  localparam int F_STABLE = 3;
  localparam int F_GAP    = 2;
  localparam int F_FIFO   = 3;

  logic       CLKCMS = 1'b0;
  logic       RST_B = 1'b0, READY = 1'b0, SOFT_RST = 1'b0, CLR_LOSS = 1'b0;
  logic       CORE_RST, FIFO_RST, L1A_EN, RUNNING;
  logic [2:0] STATE;
  logic [7:0] LOSS_CNT;

  logic       f_ready = 1'b0, f_soft = 1'b0, f_clr = 1'b0;
  logic       f_core, f_fifo, f_l1a, f_run;
  logic [2:0] f_state;
  logic [7:0] f_loss;

  int checks = 0;
  int errors = 0;

  always #5 CLKCMS = ~CLKCMS;

  clk_rst_seq dut (
    .CLKCMS(CLKCMS), .RST_B(RST_B), .READY(READY), .SOFT_RST(SOFT_RST), .CLR_LOSS(CLR_LOSS),
    .CORE_RST(CORE_RST), .FIFO_RST(FIFO_RST), .L1A_EN(L1A_EN), .RUNNING(RUNNING),
    .STATE(STATE), .LOSS_CNT(LOSS_CNT)
  );

  clk_rst_seq #(.STABLE_CYC(F_STABLE), .GAP_CYC(F_GAP), .FIFO_RST_CYC(F_FIFO)) dut_fast (
    .CLKCMS(CLKCMS), .RST_B(RST_B), .READY(f_ready), .SOFT_RST(f_soft), .CLR_LOSS(f_clr),
    .CORE_RST(f_core), .FIFO_RST(f_fifo), .L1A_EN(f_l1a), .RUNNING(f_run),
    .STATE(f_state), .LOSS_CNT(f_loss)
  );

  // Behavioural model of the short-parameter instance: phase, time spent in phase, loss count.
  int m_st = 0, m_el = 0, m_loss = 0, m_nx = 0;
  bit m_ev;

  function automatic int dwell(input int st);
    case (st)
      0:       return F_STABLE;
      2:       return F_FIFO;
      1, 3, 6: return F_GAP;
      default: return 0;
    endcase
  endfunction

  always @(posedge CLKCMS or negedge RST_B) begin
    if (!RST_B) begin
      m_st = 0; m_el = 0; m_loss = 0;
    end else begin
      m_ev = !f_ready && (m_st inside {1, 2, 3, 4, 6});
      m_nx = m_st;
      if (m_st == 5) m_nx = 0;
      else if (m_st == 0) begin
        if (f_ready && m_el + 1 >= dwell(0)) m_nx = 1;
      end else if (m_st != 4 && m_el + 1 >= dwell(m_st)) m_nx = (m_st == 6) ? 1 : m_st + 1;
      if (f_soft && (m_st inside {1, 2, 3, 4})) m_nx = 6;
      if (m_ev) m_nx = 5;
      if (f_clr) m_loss = 0;
      else if (m_ev && m_loss < 255) m_loss = m_loss + 1;
      if (m_nx != m_st || (m_st == 0 && !f_ready)) m_el = 0;
      else m_el = m_el + 1;
      m_st = m_nx;
    end
  end

  task automatic step();
    @(posedge CLKCMS);
    #1;
  endtask

  task automatic wait_main_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (STATE == s) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_fast_active(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (f_state inside {3'd1, 3'd2, 3'd3, 3'd4}) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    RST_B = 1'b0; READY = 1'b1;
    repeat (5) begin
      step();
      obs = {CORE_RST, FIFO_RST, L1A_EN, RUNNING, STATE, LOSS_CNT};
      checks++;
      if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0}) begin
        errors++; $display("FAIL reset_values got %b want %b", obs, {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
      end
    end
    RST_B = 1'b1;
  endtask

  task automatic test_default_timing();
    int tc = 0, tf = 0, tl = 0;
    for (int n = 1; n <= 1100; n++) begin
      step();
      if (tc == 0 && !CORE_RST) tc = n;
      if (tf == 0 && !FIFO_RST) tf = n;
      if (tl == 0 && L1A_EN) begin tl = n; break; end
    end
    checks++; if (tc !== 1024) begin errors++; $display("FAIL core_rst_fall edge %0d want 1024", tc); end
    checks++; if (tf !== 1048) begin errors++; $display("FAIL fifo_rst_fall edge %0d want 1048", tf); end
    checks++; if (tl !== 1056) begin errors++; $display("FAIL l1a_rise edge %0d want 1056", tl); end
    checks++; if (STATE !== 3'd4) begin errors++; $display("FAIL run_state got %0d want 4", STATE); end
    checks++; if (RUNNING !== 1'b1) begin errors++; $display("FAIL running got %b want 1", RUNNING); end
    checks++; if (LOSS_CNT !== 8'd0) begin errors++; $display("FAIL loss_after_boot got %0d want 0", LOSS_CNT); end
  endtask

  task automatic test_ready_glitch();
    int tc = 0;
    RST_B = 1'b0; step(); RST_B = 1'b1;
    for (int n = 1; n <= 1700; n++) begin
      step();
      if (n == 599) READY = 1'b0;
      if (n == 600) begin
        READY = 1'b1;
        checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL glitch_stays_wait got %0d want 0", STATE); end
      end
      if (!CORE_RST) begin tc = n; break; end
    end
    checks++; if (tc !== 1624) begin errors++; $display("FAIL glitch_core_fall edge %0d want 1624", tc); end
    checks++; if (LOSS_CNT !== 8'd0) begin errors++; $display("FAIL glitch_loss got %0d want 0", LOSS_CNT); end
  endtask

  task automatic test_lock_loss();
    bit ok;
    int tr = 0;
    wait_main_state(3'd4, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL reach_run_timeout state %0d want 4", STATE); end
    READY = 1'b0;
    step();
    READY = 1'b1;
    checks++;
    if ({STATE, CORE_RST, FIFO_RST, L1A_EN, RUNNING, LOSS_CNT} !== {3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1}) begin
      errors++; $display("FAIL lost_entry got st=%0d rst=%b%b l1a=%b run=%b loss=%0d want st=5 rst=11 l1a=0 run=0 loss=1",
                         STATE, CORE_RST, FIFO_RST, L1A_EN, RUNNING, LOSS_CNT);
    end
    step();
    checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL lost_to_wait got %0d want 0", STATE); end
    for (int n = 1; n <= 1100; n++) begin
      step();
      if (STATE == 3'd4) begin tr = n; break; end
    end
    checks++; if (tr !== 1056) begin errors++; $display("FAIL resequence_run edge %0d want 1056", tr); end
  endtask

  task automatic test_soft_reset();
    logic [2:0] es;
    SOFT_RST = 1'b1;
    for (int k = 0; k <= 45; k++) begin
      step();
      SOFT_RST = 1'b0;
      es = (k < 8) ? 3'd6 : (k < 16) ? 3'd1 : (k < 32) ? 3'd2 : (k < 40) ? 3'd3 : 3'd4;
      checks++;
      if ({STATE, CORE_RST, FIFO_RST, L1A_EN, LOSS_CNT} !== {es, k < 8, k < 32, k >= 40, 8'd1}) begin
        errors++; $display("FAIL soft_seq k=%0d got st=%0d core=%b fifo=%b l1a=%b loss=%0d want st=%0d core=%b fifo=%b l1a=%b loss=1",
                           k, STATE, CORE_RST, FIFO_RST, L1A_EN, LOSS_CNT, es, k < 8, k < 32, k >= 40);
      end
    end
  endtask

  task automatic test_async_reset();
    int tc = 0;
    SOFT_RST = 1'b1; step(); SOFT_RST = 1'b0;
    repeat (19) step();
    checks++; if (STATE !== 3'd2) begin errors++; $display("FAIL reach_fifo got %0d want 2", STATE); end
    #3 RST_B = 1'b0;
    #1;
    checks++;
    if ({STATE, CORE_RST, FIFO_RST, L1A_EN, RUNNING, LOSS_CNT} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++; $display("FAIL async_reset got st=%0d core=%b fifo=%b l1a=%b run=%b loss=%0d want st=0 core=1 fifo=1 l1a=0 run=0 loss=0",
                         STATE, CORE_RST, FIFO_RST, L1A_EN, RUNNING, LOSS_CNT);
    end
    step();
    RST_B = 1'b1;
    for (int n = 1; n <= 1100; n++) begin
      step();
      if (n == 99) SOFT_RST = 1'b1;
      if (n == 100) begin
        SOFT_RST = 1'b0;
        checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL soft_in_wait got %0d want 0", STATE); end
      end
      if (!CORE_RST) begin tc = n; break; end
    end
    checks++; if (tc !== 1024) begin errors++; $display("FAIL soft_wait_core_fall edge %0d want 1024", tc); end
  endtask

  task automatic test_saturate();
    bit ok;
    int exp_loss;
    f_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wait_fast_active(ok);
      if (!ok) begin checks++; errors++; $display("FAIL sat_active_timeout state %0d want 1..4", f_state); break; end
      f_ready = 1'b0; step(); f_ready = 1'b1;
      exp_loss = (i + 1 > 255) ? 255 : i + 1;
      checks++;
      if (f_loss !== 8'(exp_loss) || f_state !== 3'd5) begin
        errors++; $display("FAIL sat_loss i=%0d got loss=%0d st=%0d want loss=%0d st=5", i, f_loss, f_state, exp_loss);
      end
    end
    wait_fast_active(ok);
    f_ready = 1'b0; f_clr = 1'b1; step(); f_ready = 1'b1; f_clr = 1'b0;
    checks++; if (f_loss !== 8'd0) begin errors++; $display("FAIL clr_wins got %0d want 0", f_loss); end
    wait_fast_active(ok);
    f_ready = 1'b0; step(); f_ready = 1'b1;
    checks++; if (f_loss !== 8'd1) begin errors++; $display("FAIL loss_after_clr got %0d want 1", f_loss); end
  endtask

  task automatic test_random();
    logic [3:0] ev;
    for (int c = 0; c < 3000; c++) begin
      f_ready = ($urandom_range(0, 15) != 0);
      f_soft  = ($urandom_range(0, 24) == 0);
      f_clr   = ($urandom_range(0, 199) == 0);
      step();
      ev = {m_st == 0 || m_st == 5 || m_st == 6, m_st == 0 || m_st == 1 || m_st == 2 || m_st == 5 || m_st == 6,
            m_st == 4, m_st == 4};
      checks++;
      if (f_state !== 3'(m_st)) begin errors++; $display("FAIL rand_state c=%0d got %0d want %0d", c, f_state, m_st); end
      checks++;
      if ({f_core, f_fifo, f_l1a, f_run} !== ev) begin
        errors++; $display("FAIL rand_outputs c=%0d got %b want %b", c, {f_core, f_fifo, f_l1a, f_run}, ev);
      end
      checks++;
      if (f_loss !== 8'(m_loss)) begin errors++; $display("FAIL rand_loss c=%0d got %0d want %0d", c, f_loss, m_loss); end
    end
  endtask

  initial begin
    test_reset();
    test_default_timing();
    test_ready_glitch();
    test_lock_loss();
    test_soft_reset();
    test_async_reset();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
